// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: state encoding, default timing constants and transition rules for the stopwatch controller
package stopwatch_pkg;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_STOP = 2'd2, S_LAP = 2'd3} state_t;
  localparam int DEB_CYCLES_DEF = 50000;
  localparam int TICK_DIV_DEF = 500000;
  function automatic state_t next_state(input state_t s, input logic k1, input logic k2, input logic lap_en);
    if (k1) return (s == S_RUN || s == S_LAP) ? S_STOP : S_RUN;
    if (k2) return s == S_RUN ? (lap_en ? S_LAP : S_RUN) : s == S_LAP ? S_RUN : S_IDLE;
    return s;
  endfunction
  function automatic logic clr_req(input state_t s, input logic k1, input logic k2);
    return k2 && !k1 && (s == S_IDLE || s == S_STOP);
  endfunction
endpackage

// File: rtl/key_debounce.sv
// key_debounce: 2-FF synchronizer, stability debounce and one-cycle press pulse for an active-low key
module key_debounce
  import stopwatch_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key,
  output logic press
);
  localparam int CW = $clog2(DEB_CYCLES + 1);
  logic sync1, sync2, level, armed;
  logic [1:0] fill;
  logic [CW-1:0] cnt;
  logic settle;
  assign settle = (sync2 != level) && cnt == CW'(DEB_CYCLES - 1);
  // sync, count consecutive disagreeing samples, and only arm once a real released sample is seen
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      level <= 1'b1;
      fill  <= '0;
      armed <= 1'b0;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync1 <= key;
      sync2 <= sync1;
      fill  <= {fill[0], 1'b1};
      armed <= armed | (fill[1] & sync2);
      cnt   <= (sync2 != level && !settle) ? cnt + CW'(1) : '0;
      level <= settle ? sync2 : level;
      press <= settle && !sync2 && armed;
    end
endmodule

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: key-driven stopwatch FSM with centisecond prescaler; define STOPWATCH_LAP_EN for the lap/hold state
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF,
  parameter int TICK_DIV = TICK_DIV_DEF
) (
  input  logic       CLOCK2_50,
  input  logic       KEY0,
  input  logic       KEY1,
  input  logic       KEY2,
  output logic       run,
  output logic       tick,
  output logic       clr,
  output logic       hold,
  output logic [1:0] state
);
`ifdef STOPWATCH_LAP_EN
  localparam logic LAP_EN = 1'b1;
`else
  localparam logic LAP_EN = 1'b0;
`endif
  localparam int PW = $clog2(TICK_DIV);
  state_t st, nxt;
  logic k1, k2;
  logic [PW-1:0] pre;
  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_key1 (.clk(CLOCK2_50), .rst_n(KEY0), .key(KEY1), .press(k1));
  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_key2 (.clk(CLOCK2_50), .rst_n(KEY0), .key(KEY2), .press(k2));
  assign nxt = next_state(st, k1, k2, LAP_EN);
  assign state = st;
  assign tick = run && pre == PW'(TICK_DIV - 1);
  // state register with outputs registered alongside the next state
  always_ff @(posedge CLOCK2_50 or negedge KEY0)
    if (!KEY0) begin
      st   <= S_IDLE;
      run  <= 1'b0;
      hold <= 1'b0;
      clr  <= 1'b0;
    end else begin
      st   <= nxt;
      run  <= nxt == S_RUN || nxt == S_LAP;
      hold <= LAP_EN && nxt == S_LAP;
      clr  <= clr_req(st, k1, k2);
    end
  // prescaler advances only while running, keeps its phase when stopped, zeroed by clr
  always_ff @(posedge CLOCK2_50 or negedge KEY0)
    if (!KEY0) pre <= '0;
    else pre <= clr ? '0 : !run ? pre : tick ? '0 : pre + PW'(1);
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: randomized key stimulus against an event-level scoreboard model
module tb_stopwatch_ctrl;
  localparam int EV_STATE = 0, EV_CLR = 1, EV_TICK = 2;
  typedef struct {int kind; int val; longint at;} ev_t;
  logic clk = 1'b0, key0 = 1'b0, key1 = 1'b1, key2 = 1'b1;
  logic run, tick, clr, hold;
  logic [1:0] state, prev_st = 2'd0;
  int tests = 0, fails = 0, m_st = 0, m_r = 0, mon_exp;
  int nxt_tab[4][2];
  longint cyc = 0;
  bit mon_en = 1'b0;
  ev_t q[$];
`ifdef STOPWATCH_LAP_EN
  bit lap_en = 1'b1;
`else
  bit lap_en = 1'b0;
`endif
  stopwatch_ctrl #(.DEB_CYCLES(4), .TICK_DIV(10)) dut (
    .CLOCK2_50(clk), .KEY0(key0), .KEY1(key1), .KEY2(key2),
    .run(run), .tick(tick), .clr(clr), .hold(hold), .state(state)
  );
  // free-running clock
  always #5 clk = ~clk;
  // count rising edges so events can be stamped with a cycle number
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  function automatic void push(input int kind, input int val, input longint at);
    ev_t e;
    e.kind = kind;
    e.val = val;
    e.at = at;
    q.push_back(e);
  endfunction
  function automatic void model_run(input longint a, input longint b);
    for (longint c = a; c < b; c++)
      if (m_st == 1 || m_st == 3) begin
        if (m_r % 10 == 9) push(EV_TICK, 0, c);
        m_r++;
      end
  endfunction
  task automatic take(input int kind, input int val, output int expv);
    ev_t e;
    tests++;
    expv = val;
    if (q.size() == 0) begin
      fails++;
      $display("FAIL unexpected_event: got kind %0d value %0d at cycle %0d, none expected", kind, val, cyc);
    end else begin
      e = q.pop_front();
      expv = e.val;
      if (e.kind != kind || e.val != val || e.at != cyc) begin
        fails++;
        $display("FAIL event: got kind %0d value %0d cycle %0d, expected kind %0d value %0d cycle %0d",
                 kind, val, cyc, e.kind, e.val, e.at);
      end
    end
  endtask
  // monitor: every state change, clr pulse and tick is matched against the scoreboard
  always @(negedge clk)
    if (mon_en) begin
      if (state !== prev_st) begin
        take(EV_STATE, int'(state), mon_exp);
        prev_st = state;
        chk("run_level", run, mon_exp == 1 || mon_exp == 3);
        chk("hold_level", hold, lap_en && mon_exp == 3);
      end
      if (clr) take(EV_CLR, 0, mon_exp);
      if (tick) take(EV_TICK, 0, mon_exp);
    end
  task automatic press_op(input bit k1, input bit k2, input int low, input int rel);
    longint t0, t;
    int ns;
    t0 = cyc;
    t = t0 + 7;
    if (low >= 4 && (k1 || k2)) begin
      ns = k1 ? nxt_tab[m_st][0] : nxt_tab[m_st][1];
      model_run(t0, t);
      if (ns != m_st) push(EV_STATE, ns, t);
      if (!k1 && (m_st == 0 || m_st == 2)) begin
        push(EV_CLR, 0, t);
        m_r = 0;
      end
      m_st = ns;
      model_run(t, t0 + low + rel);
    end else model_run(t0, t0 + low + rel);
    key1 = !k1;
    key2 = !k2;
    repeat (low) @(posedge clk);
    #1;
    key1 = 1'b1;
    key2 = 1'b1;
    repeat (rel) @(posedge clk);
    #1;
  endtask
  task automatic wait_op(input int n);
    model_run(cyc, cyc + n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic reset_op();
    chk("queue_empty_before_reset", q.size(), 0);
    mon_en = 1'b0;
    key1 = 1'b0;
    key0 = 1'b0;
    #1;
    chk("rst_state", state, 0);
    chk("rst_run", run, 0);
    chk("rst_hold", hold, 0);
    chk("rst_tick", tick, 0);
    chk("rst_clr", clr, 0);
    repeat (3) @(posedge clk);
    #1;
    m_st = 0;
    m_r = 0;
    prev_st = 2'd0;
    key0 = 1'b1;
    mon_en = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    key1 = 1'b1;
    repeat (10) @(posedge clk);
    #1;
  endtask
  initial begin
    int r, low, rel;
    nxt_tab[0][0] = 1; nxt_tab[0][1] = 0;
    nxt_tab[1][0] = 2; nxt_tab[1][1] = lap_en ? 3 : 1;
    nxt_tab[2][0] = 1; nxt_tab[2][1] = 0;
    nxt_tab[3][0] = 2; nxt_tab[3][1] = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("init_state", state, 0);
    chk("init_run", run, 0);
    chk("init_tick", tick, 0);
    chk("init_clr", clr, 0);
    chk("init_hold", hold, 0);
    key0 = 1'b1;
    mon_en = 1'b1;
    wait_op(5);
    press_op(1'b1, 1'b0, 10, 10);
    wait_op(35);
    press_op(1'b1, 1'b0, 3, 10);
    press_op(1'b0, 1'b1, 5, 10);
    wait_op(23);
    press_op(1'b1, 1'b1, 6, 10);
    press_op(1'b1, 1'b0, 5, 10);
    wait_op(17);
    reset_op();
    for (int i = 0; i < 80; i++) begin
      r = $urandom_range(0, 11);
      low = $urandom_range(4, 9);
      rel = $urandom_range(8, 12);
      if (r < 4) press_op(1'b1, 1'b0, low, rel);
      else if (r < 7) press_op(1'b0, 1'b1, low, rel);
      else if (r == 7) press_op(1'b1, 1'b1, low, rel);
      else if (r == 8) press_op($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom_range(1, 3), rel);
      else if (r == 9 && $urandom_range(0, 3) == 0) reset_op();
      else wait_op($urandom_range(1, 30));
    end
    wait_op(20);
    chk("queue_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 SHALL have parameter DEB_CYCLES, 50000, debounce stability count in clocks (1 ms at 50 MHz).
REQ-002 SHALL have parameter TICK_DIV, 500000, clocks per centisecond tick (100 Hz at 50 MHz).
REQ-003 SHALL have port CLOCK2_50  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port KEY0  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port KEY1  input  1  start/stop button, active-low, asynchronous to clock.
REQ-006 SHALL have port KEY2  input  1  lap/clear button, active-low, asynchronous to clock.
REQ-007 SHALL have port run  output  1  counter enable, high in RUN and LAP.
REQ-008 SHALL have port tick  output  1  one-cycle centisecond advance pulse for the time counter.
REQ-009 SHALL have port clr  output  1  one-cycle synchronous clear pulse for the time counter.
REQ-010 SHALL have port hold  output  1  display freeze (lap), high only in LAP.
REQ-011 SHALL have port state  output  2  current FSM state encoding.

Function
REQ-012 Each key SHALL pass a 2-FF synchronizer; debounced level (reset 1) SHALL update only after the synced sample differs from it for DEB_CYCLES consecutive clocks; any agreement restarts the count.
REQ-013 A press event SHALL be a one-cycle pulse on the debounced 1->0 transition; release SHALL generate no event.
REQ-014 FSM states: IDLE=0, RUN=1, STOP=2, LAP=3; transitions take effect the cycle after the press event.
REQ-015 IDLE: KEY1 press -> RUN; KEY2 press -> IDLE with clr pulse.
REQ-016 RUN: KEY1 press -> STOP; KEY2 press -> LAP.
REQ-017 LAP: KEY1 press -> STOP (hold drops); KEY2 press -> RUN (hold drops); counting continues throughout LAP.
REQ-018 STOP: KEY1 press -> RUN; KEY2 press -> IDLE with clr pulse in the transition cycle.
REQ-019 Simultaneous KEY1 and KEY2 events in one cycle: KEY1 SHALL win, KEY2 event discarded.
REQ-020 Prescaler SHALL count 0..TICK_DIV-1 only while run=1; tick SHALL be high the cycle count equals TICK_DIV-1, count then wraps to 0.
REQ-021 Prescaler SHALL hold its value in STOP (phase preserved on resume) and SHALL be zeroed on every clr pulse.
REQ-022 tick and clr SHALL never be high in the same cycle.

Reset
REQ-023 KEY0 low SHALL immediately force state=IDLE, run=0, hold=0, tick=0, clr=0, prescaler=0, debounce counters=0, debounced levels=1, synchronizers=1.
REQ-024 Reset asserted mid-operation SHALL abort any pending debounce; no press event SHALL be generated on reset release even if a key is held.

Configuration
REQ-025 Macro STOPWATCH_LAP_EN defined: LAP state and hold behave as above.
REQ-026 Macro undefined: LAP unreachable, hold tied 0, KEY2 in RUN ignored; IDLE/STOP KEY2 behaviour unchanged.

Structure
REQ-027 Package stopwatch_pkg SHALL hold the state encoding typedef and default DEB_CYCLES/TICK_DIV constants.
REQ-028 Sub-module key_debounce (synchronizer, debounce, press event) SHALL be instantiated once per key.

Verification (DEB_CYCLES=4, TICK_DIV=10)
REQ-029 Reset, KEY1 held low 10 clocks -> one press event, state 0->1, run=1, tick every 10th clock thereafter.
REQ-030 KEY1 glitch low 3 clocks -> no event, state stays 0.
REQ-031 RUN, KEY1 press at prescaler=6 -> STOP, no ticks; KEY1 press -> RUN, first tick 3 clocks after resume.
REQ-032 STOP, KEY2 press -> single clr pulse, state=0, prescaler=0.
REQ-033 With STOPWATCH_LAP_EN: RUN, KEY2 -> hold=1, ticks continue; KEY2 -> hold=0, state=1; without macro KEY2 in RUN -> no change.
REQ-034 KEY1 and KEY2 released-to-pressed identically in RUN -> state=2, hold=0; KEY0 low mid-RUN -> all outputs 0, state=0 same cycle.
